// File: rtl/aes_gcm_ghash_tag_if.sv
// ---------------------------------------------------------------------------
// aes_gcm_ghash_tag_if
//
// Bundle of the per-instance setup inputs, the block stream handshake and the
// tag outputs of the GHASH/tag engine. Every 128-bit vector is declared [0:127]
// so that bit 0 is the leftmost (most significant) bit, matching GCM notation.
//
// Parameters:
//   LEN_W          width of the AAD/ciphertext bit-length fields
//
// Signals (direction seen from the engine):
//   i_start        in   new-instance pulse, samples the four fields below
//   i_h            in   hash subkey H
//   i_encrypted_j0 in   E(K,J0)
//   i_aad_len      in   AAD length in bits
//   i_ct_len       in   ciphertext length in bits
//   i_valid        in   i_data carries a block
//   i_data         in   AAD or ciphertext block, in stream order
//   o_ready        out  engine accepts i_data this cycle
//   o_busy         out  instance in progress
//   o_tag_valid    out  o_tag holds the final tag
//   o_tag          out  authentication tag
//
// Modports: master drives the stream (testbench / upstream CTR stage),
//           slave is the engine.
// ---------------------------------------------------------------------------
interface aes_gcm_ghash_tag_if #(
    parameter int LEN_W = 64
);
    logic             i_start;
    logic [0:127]     i_h;
    logic [0:127]     i_encrypted_j0;
    logic [0:LEN_W-1] i_aad_len;
    logic [0:LEN_W-1] i_ct_len;
    logic             i_valid;
    logic [0:127]     i_data;
    logic             o_ready;
    logic             o_busy;
    logic             o_tag_valid;
    logic [0:127]     o_tag;

    modport master (
        output i_start, i_h, i_encrypted_j0, i_aad_len, i_ct_len, i_valid, i_data,
        input  o_ready, o_busy, o_tag_valid, o_tag
    );

    modport slave (
        input  i_start, i_h, i_encrypted_j0, i_aad_len, i_ct_len, i_valid, i_data,
        output o_ready, o_busy, o_tag_valid, o_tag
    );
endinterface

// File: rtl/aes_gcm_ghash_tag.sv
// ---------------------------------------------------------------------------
// aes_gcm_ghash_tag
//
// GHASH accumulator and tag generator for AES-GCM. On i_start it latches H,
// E(K,J0) and the two bit lengths, then folds Na AAD blocks, Nc ciphertext
// blocks and finally the internal length block {aad_len, ct_len} into
// S = (S ^ X) * H over GF(2^128), and emits S ^ E(K,J0) as the tag.
//
// Parameters:
//   LEN_W    width of the length inputs (8..64)
//   MUL_LAT  register stages in the multiplier path (1..4); one block is
//            accepted every MUL_LAT cycles
//
// Ports:
//   clk      clock, rising edge
//   rst      asynchronous active-high reset
//   bus      aes_gcm_ghash_tag_if.slave (setup, block stream, tag)
//
// Build option:
//   AES_GCM_PARTIAL_BLK_EN  when defined, block counts round up and the last
//                           AAD / ciphertext block is masked to its valid bits;
//                           otherwise counts are len>>7 and no masking is done.
// ---------------------------------------------------------------------------
module aes_gcm_ghash_tag #(
    parameter int LEN_W   = 64,
    parameter int MUL_LAT = 1
) (
    input logic                 clk,
    input logic                 rst,
    aes_gcm_ghash_tag_if.slave  bus
);

    localparam int CNT_W = LEN_W - 6;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [0:127] GF_R = {8'he1, 120'h0};

    // TAG is a one-cycle step between the length block landing in S and the
    // registered tag output.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AAD,
        ST_CT,
        ST_LEN,
        ST_TAG,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] aad_len_q, aad_len_d;
    logic [LEN_W-1:0] ct_len_q, ct_len_d;
    logic [CNT_W-1:0] na_q, na_d;
    logic [CNT_W-1:0] nc_q, nc_d;
    logic [0:127]     h_q, h_d;
    logic [0:127]     ej0_q, ej0_d;
    logic [0:127]     s_q, s_d;
    logic [0:127]     tag_q, tag_d;
    logic             tag_valid_q, tag_valid_d;
    logic             len_sent_q, len_sent_d;
    logic [0:127]     v_q [MUL_LAT];
    logic [0:127]     v_d [MUL_LAT];
    logic [MUL_LAT-1:0] vld_q, vld_d;

    logic             ready;
    logic             accept;
    logic             land;
    logic             mul_free;
    logic [0:127]     mul_out;
    logic [0:127]     s_eff;
    logic [0:127]     len_blk;
    logic [0:127]     aad_mask;
    logic [0:127]     ct_mask;
    logic             launch;
    logic [0:127]     launch_blk;

    // GF(2^128) product in the bit-reflected GCM convention: bit 0 is the
    // x^0 coefficient, so a right shift multiplies by x.
    function automatic logic [0:127] gf_mul(input logic [0:127] x, input logic [0:127] y);
        logic [0:127] z;
        logic [0:127] v;
        z = '0;
        v = y;
        for (int i = 0; i < 128; i++) begin
            if (x[i]) z = z ^ v;
            if (v[127]) v = (v >> 1) ^ GF_R;
            else        v = v >> 1;
        end
        return z;
    endfunction

    function automatic logic [CNT_W-1:0] blk_count(input logic [LEN_W-1:0] len);
`ifdef AES_GCM_PARTIAL_BLK_EN
        return CNT_W'(len >> 7) + CNT_W'(len[6:0] != 7'd0);
`else
        return CNT_W'(len >> 7);
`endif
    endfunction

`ifdef AES_GCM_PARTIAL_BLK_EN
    // Keeps bits [0:r-1] of a block, r = len mod 128; a full block when r = 0.
    function automatic logic [0:127] tail_mask(input logic [LEN_W-1:0] len);
        logic [6:0] r;
        r = len[6:0];
        if (r == 7'd0) return '1;
        return ~({128{1'b1}} >> r);
    endfunction
`endif

    // The operand pipeline feeds the multiplier from its last stage; the
    // product written into S on the next edge is forwarded as s_eff so a block
    // accepted on that same edge already sees the updated accumulator.
    assign land     = vld_q[MUL_LAT-1];
    assign mul_out  = gf_mul(v_q[MUL_LAT-1], h_q);
    assign s_eff    = land ? mul_out : s_q;
    assign len_blk  = {64'(aad_len_q), 64'(ct_len_q)};

    // Multiplier can take a new operand when nothing is in flight except the
    // product that lands at the coming edge.
    always_comb begin
        mul_free = 1'b1;
        for (int k = 0; k < MUL_LAT - 1; k++) begin
            if (vld_q[k]) mul_free = 1'b0;
        end
    end

    // Tail masks apply only to the last block of each section.
    always_comb begin
`ifdef AES_GCM_PARTIAL_BLK_EN
        aad_mask = (na_q == CNT_ONE) ? tail_mask(aad_len_q) : '1;
        ct_mask  = (nc_q == CNT_ONE) ? tail_mask(ct_len_q)  : '1;
`else
        aad_mask = '1;
        ct_mask  = '1;
`endif
    end

    assign ready  = ((state_q == ST_AAD) || (state_q == ST_CT)) && mul_free;
    assign accept = bus.i_valid && ready;

    // Next-state logic: section sequencing, block launch into the multiplier
    // pipeline, and the i_start override which wins over everything else.
    always_comb begin
        state_d     = state_q;
        aad_len_d   = aad_len_q;
        ct_len_d    = ct_len_q;
        na_d        = na_q;
        nc_d        = nc_q;
        h_d         = h_q;
        ej0_d       = ej0_q;
        s_d         = s_q;
        tag_d       = tag_q;
        tag_valid_d = tag_valid_q;
        len_sent_d  = len_sent_q;
        launch      = 1'b0;
        launch_blk  = '0;
        v_d         = v_q;
        vld_d       = '0;
        for (int k = 1; k < MUL_LAT; k++) begin
            vld_d[k] = vld_q[k-1];
            v_d[k]   = v_q[k-1];
        end

        if (land) s_d = mul_out;

        unique case (state_q)
            ST_AAD: begin
                if (accept) begin
                    launch     = 1'b1;
                    launch_blk = bus.i_data & aad_mask;
                    na_d       = na_q - CNT_ONE;
                    if (na_q == CNT_ONE) state_d = (nc_q != '0) ? ST_CT : ST_LEN;
                end
            end
            ST_CT: begin
                if (accept) begin
                    launch     = 1'b1;
                    launch_blk = bus.i_data & ct_mask;
                    nc_d       = nc_q - CNT_ONE;
                    if (nc_q == CNT_ONE) state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (!len_sent_q) begin
                    if (mul_free) begin
                        launch     = 1'b1;
                        launch_blk = len_blk;
                        len_sent_d = 1'b1;
                    end
                end else if (land) begin
                    state_d = ST_TAG;
                end
            end
            ST_TAG: begin
                tag_d       = s_q ^ ej0_q;
                tag_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
            default: begin
            end
        endcase

        if (launch) begin
            v_d[0]   = s_eff ^ launch_blk;
            vld_d[0] = 1'b1;
        end

        if (bus.i_start) begin
            h_d         = bus.i_h;
            ej0_d       = bus.i_encrypted_j0;
            aad_len_d   = bus.i_aad_len;
            ct_len_d    = bus.i_ct_len;
            na_d        = blk_count(bus.i_aad_len);
            nc_d        = blk_count(bus.i_ct_len);
            s_d         = '0;
            vld_d       = '0;
            tag_d       = '0;
            tag_valid_d = 1'b0;
            len_sent_d  = 1'b0;
            if (na_d != '0)      state_d = ST_AAD;
            else if (nc_d != '0) state_d = ST_CT;
            else                 state_d = ST_LEN;
        end
    end

    // State and datapath registers; reset returns every output to zero at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            aad_len_q   <= '0;
            ct_len_q    <= '0;
            na_q        <= '0;
            nc_q        <= '0;
            h_q         <= '0;
            ej0_q       <= '0;
            s_q         <= '0;
            tag_q       <= '0;
            tag_valid_q <= 1'b0;
            len_sent_q  <= 1'b0;
            vld_q       <= '0;
            for (int k = 0; k < MUL_LAT; k++) v_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            aad_len_q   <= aad_len_d;
            ct_len_q    <= ct_len_d;
            na_q        <= na_d;
            nc_q        <= nc_d;
            h_q         <= h_d;
            ej0_q       <= ej0_d;
            s_q         <= s_d;
            tag_q       <= tag_d;
            tag_valid_q <= tag_valid_d;
            len_sent_q  <= len_sent_d;
            vld_q       <= vld_d;
            v_q         <= v_d;
        end
    end

    assign bus.o_ready     = ready;
    assign bus.o_busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign bus.o_tag_valid = tag_valid_q;
    assign bus.o_tag       = tag_q;

endmodule

// File: tb/tb_aes_gcm_ghash_tag.sv
// ---------------------------------------------------------------------------
// tb_aes_gcm_ghash_tag
//
// Drives NIST vectors and random instances into aes_gcm_ghash_tag (MUL_LAT=3)
// and compares tags, handshake spacing and latencies against a polynomial
// reference model (carry-less product followed by reduction modulo
// x^128 + x^7 + x^2 + x + 1).
// ---------------------------------------------------------------------------
module tb_aes_gcm_ghash_tag;

    localparam int LEN_W   = 64;
    localparam int MUL_LAT = 3;

    localparam logic [0:127] H1   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [0:127] EJ1  = 128'h58e2fccefa7e3061367f1d57a4e7455a;
    localparam logic [0:127] C2   = 128'h0388dace60b6a392f328c2b971b2fe78;
    localparam logic [0:127] TAG2 = 128'hab6e47d42cec13bdf53a67b21257bddf;

    logic clk = 1'b0;
    logic rst;
    int   checkCount = 0;
    int   errorCount = 0;
    logic [0:127] blkQ [$];

    always #5 clk = ~clk;

    aes_gcm_ghash_tag_if #(.LEN_W(LEN_W)) bus ();

    aes_gcm_ghash_tag #(.LEN_W(LEN_W), .MUL_LAT(MUL_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Single comparison point: counts and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Polynomial product: coefficient of x^i is bit i of the block.
    function automatic logic [0:127] polyMul(input logic [0:127] a, input logic [0:127] b);
        logic [0:254] c;
        c = '0;
        for (int i = 0; i < 128; i++)
            if (a[i])
                for (int j = 0; j < 128; j++)
                    if (b[j]) c[i+j] = ~c[i+j];
        for (int d = 254; d >= 128; d--) begin
            if (c[d]) begin
                c[d]       = 1'b0;
                c[d - 128] = ~c[d - 128];
                c[d - 127] = ~c[d - 127];
                c[d - 126] = ~c[d - 126];
                c[d - 121] = ~c[d - 121];
            end
        end
        return c[0:127];
    endfunction

    function automatic int refCount(input logic [63:0] len);
`ifdef AES_GCM_PARTIAL_BLK_EN
        return int'((len + 64'd127) / 64'd128);
`else
        return int'(len / 64'd128);
`endif
    endfunction

    function automatic logic [0:127] refTag(input logic [0:127] h, input logic [0:127] ej0,
                                            input logic [63:0] aadLen, input logic [63:0] ctLen,
                                            input logic [0:127] blocks [$]);
        logic [0:127] s;
        logic [0:127] x;
        int na;
        int nc;
        na = refCount(aadLen);
        nc = refCount(ctLen);
        s  = '0;
        for (int i = 0; i < na + nc; i++) begin
            x = blocks[i];
`ifdef AES_GCM_PARTIAL_BLK_EN
            if (i == na - 1 && aadLen % 128 != 0)
                for (int b = int'(aadLen % 128); b < 128; b++) x[b] = 1'b0;
            if (i == na + nc - 1 && i >= na && ctLen % 128 != 0)
                for (int b = int'(ctLen % 128); b < 128; b++) x[b] = 1'b0;
`endif
            s = polyMul(s ^ x, h);
        end
        s = polyMul(s ^ {aadLen, ctLen}, h);
        return s ^ ej0;
    endfunction

    function automatic logic [0:127] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Runs one instance from blkQ; called #1 after a rising edge. abortAfter>0
    // returns as soon as that many blocks were accepted, leaving it in flight.
    task automatic applyStimulus(input string name, input logic [0:127] h, input logic [0:127] ej0,
                                 input logic [63:0] aadLen, input logic [63:0] ctLen,
                                 input bit randValid, input int abortAfter);
        int nBlk, idx, accepts, cycle, lastAccept, prevAccept, tagCycle;
        int sinceAccept, gapErrs, spacingErrs;
        bit willAccept, seenTag, busyFirst, readyFirst, readyEver, staleTag;
        logic [0:127] expTag;
        nBlk   = blkQ.size();
        expTag = refTag(h, ej0, aadLen, ctLen, blkQ);
        bus.i_start = 1'b1;
        bus.i_h = h;
        bus.i_encrypted_j0 = ej0;
        bus.i_aad_len = aadLen;
        bus.i_ct_len = ctLen;
        bus.i_valid = 1'b0;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        cycle = 0; idx = 0; accepts = 0; lastAccept = -1; prevAccept = -1; tagCycle = -1;
        sinceAccept = MUL_LAT; gapErrs = 0; spacingErrs = 0; seenTag = 1'b0;
        busyFirst = bus.o_busy; readyFirst = bus.o_ready; staleTag = bus.o_tag_valid;
        readyEver = 1'b0;
        while (cycle < 400 && !seenTag) begin
            if (idx < nBlk) begin
                bus.i_valid = randValid ? 1'($urandom_range(0, 1)) : 1'b1;
                bus.i_data  = blkQ[idx];
            end else begin
                bus.i_valid = 1'($urandom_range(0, 1));
                bus.i_data  = rand128();
            end
            if (bus.o_ready) readyEver = 1'b1;
            if (bus.o_ready && sinceAccept < MUL_LAT - 1) gapErrs++;
            willAccept = bus.i_valid && bus.o_ready;
            @(posedge clk);
            cycle++;
            sinceAccept++;
            if (willAccept) begin
                if (!randValid && prevAccept >= 0 && cycle - prevAccept != MUL_LAT) spacingErrs++;
                prevAccept = cycle; lastAccept = cycle; sinceAccept = 0;
                accepts++; idx++;
            end
            #1;
            if (bus.o_tag_valid) begin
                seenTag  = 1'b1;
                tagCycle = cycle;
            end
            if (abortAfter > 0 && accepts == abortAfter) break;
        end
        bus.i_valid = 1'b0;
        checkOutput({name, "_no_stale_tag"}, staleTag, 1'b0);
        checkOutput({name, "_busy_t1"}, busyFirst, 1'b1);
        if (abortAfter > 0) begin
            checkOutput({name, "_abort_accepts"}, accepts, abortAfter);
            checkOutput({name, "_abort_tag_valid"}, bus.o_tag_valid, 1'b0);
            return;
        end
        checkOutput({name, "_tag_seen"}, seenTag, 1'b1);
        checkOutput({name, "_ready_t1"}, readyFirst, nBlk > 0);
        checkOutput({name, "_ready_ever"}, readyEver, nBlk > 0);
        checkOutput({name, "_accepts"}, accepts, nBlk);
        checkOutput({name, "_ready_gap"}, gapErrs, 0);
        if (!randValid) checkOutput({name, "_accept_spacing"}, spacingErrs, 0);
        if (nBlk > 0) checkOutput({name, "_latency"}, tagCycle - lastAccept, 2 * MUL_LAT + 1);
        else          checkOutput({name, "_latency"}, tagCycle, MUL_LAT + 2);
        checkOutput({name, "_tag"}, bus.o_tag, expTag);
        checkOutput({name, "_busy_done"}, bus.o_busy, 1'b0);
        repeat (3) begin
            bus.i_valid = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        bus.i_valid = 1'b0;
        checkOutput({name, "_tag_hold"}, {bus.o_tag_valid, bus.o_tag}, {1'b1, expTag});
    endtask

    initial begin
        logic [63:0] aLen;
        logic [63:0] cLen;
        int na;
        int nc;
        rst = 1'b1;
        bus.i_start = 1'b0;
        bus.i_h = '0;
        bus.i_encrypted_j0 = '0;
        bus.i_aad_len = '0;
        bus.i_ct_len = '0;
        bus.i_valid = 1'b0;
        bus.i_data = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ready", bus.o_ready, 1'b0);
        checkOutput("rst_busy", bus.o_busy, 1'b0);
        checkOutput("rst_tag_valid", bus.o_tag_valid, 1'b0);
        checkOutput("rst_tag", bus.o_tag, 128'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] NIST TC1 / TC2");
        blkQ = {};
        applyStimulus("tc1", H1, EJ1, 64'd0, 64'd0, 1'b0, 0);
        checkOutput("tc1_nist", bus.o_tag, EJ1);
        blkQ = {C2};
        applyStimulus("tc2", H1, EJ1, 64'd0, 64'd128, 1'b0, 0);
        checkOutput("tc2_nist", bus.o_tag, TAG2);

`ifdef AES_GCM_PARTIAL_BLK_EN
        $display("[TB] NIST TC4 with tail garbage");
        begin
            logic [0:127] a2;
            logic [0:127] c4;
            a2 = rand128();
            a2[0:31] = 32'habaddad2;
            c4 = rand128();
            c4[0:95] = 96'h1ba30b396a0aac973d58e091;
            blkQ = {128'hfeedfacedeadbeeffeedfacedeadbeef, a2,
                    128'h42831ec2217774244b7221b784d0d49c,
                    128'he3aa212f2c02a4e035c17e2329aca12e,
                    128'h21d514b25466931c7d8f6a5aac84aa05, c4};
            applyStimulus("tc4", 128'hb83b533708bf535d0aa6e52980d53b78,
                          128'h3247184b3c4f69a44dbcd22887bbb418, 64'd160, 64'd480, 1'b1, 0);
            checkOutput("tc4_nist", bus.o_tag, 128'h5bc94fbc3221a5db94fae95ae7121a47);
        end
`endif

        $display("[TB] random instances");
        for (int r = 0; r < 8; r++) begin
            na = $urandom_range(0, 3);
            nc = $urandom_range(0, 3);
`ifdef AES_GCM_PARTIAL_BLK_EN
            aLen = (na == 0) ? 64'd0 : 64'(128 * (na - 1) + $urandom_range(1, 128));
            cLen = (nc == 0) ? 64'd0 : 64'(128 * (nc - 1) + $urandom_range(1, 128));
`else
            aLen = 64'(128 * na + $urandom_range(0, 127));
            cLen = 64'(128 * nc + $urandom_range(0, 127));
`endif
            blkQ = {};
            for (int b = 0; b < refCount(aLen) + refCount(cLen); b++) blkQ.push_back(rand128());
            applyStimulus($sformatf("rnd%0d", r), rand128(), rand128(), aLen, cLen, r[0], 0);
        end

        $display("[TB] abort then TC1");
        blkQ = {C2};
        applyStimulus("abort", H1, EJ1, 64'd0, 64'd128, 1'b0, 1);
        blkQ = {};
        applyStimulus("tc1_after_abort", H1, EJ1, 64'd0, 64'd0, 1'b0, 0);
        checkOutput("tc1_after_abort_nist", bus.o_tag, EJ1);

        $display("[TB] async reset mid-CT");
        bus.i_start = 1'b1;
        bus.i_h = H1;
        bus.i_encrypted_j0 = EJ1;
        bus.i_aad_len = '0;
        bus.i_ct_len = 64'd384;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        bus.i_valid = 1'b1;
        bus.i_data = rand128();
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        checkOutput("pre_rst_busy", bus.o_busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_outputs", {bus.o_ready, bus.o_busy, bus.o_tag_valid, bus.o_tag},
                    131'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post_rst_busy", bus.o_busy, 1'b0);
        blkQ = {C2};
        applyStimulus("tc2_after_rst", H1, EJ1, 64'd0, 64'd128, 1'b0, 0);
        checkOutput("tc2_after_rst_nist", bus.o_tag, TAG2);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
